// File: rtl/flood_fill.sv
// flood_fill: one-ring-per-clock wavefront expansion of auto-revealed tiles from an opened tile.
// Optional macro FLOOD_DIAG_EN: 8-connected neighbourhood (diagonals included); default is 4-connected.
module flood_fill #(
    parameter int GRID_SIZE   = 8,
    parameter int TOTAL_TILES = GRID_SIZE * GRID_SIZE,
    parameter int INDEX_BITS  = $clog2(TOTAL_TILES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INDEX_BITS-1:0]  start_index,
    input  logic [TOTAL_TILES-1:0] zero_mask,
    input  logic [TOTAL_TILES-1:0] mine_mask,
    input  logic [TOTAL_TILES-1:0] flagged,
    input  logic [TOTAL_TILES-1:0] revealed,
    output logic                   busy,
    output logic [TOTAL_TILES-1:0] flood_update,
    output logic                   flood_apply
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t                 state_q;
    logic [TOTAL_TILES-1:0] mask_q, frontier_q, update_q, grow_d, start_bit;
    logic [INDEX_BITS-1:0]  iter_q;
    logic                   busy_q, apply_q, accept, done;

    // Every tile orthogonally (and optionally diagonally) adjacent to a set bit, clipped at grid edges
    function automatic logic [TOTAL_TILES-1:0] nbr(input logic [TOTAL_TILES-1:0] s);
        logic [TOTAL_TILES-1:0] n;
        n = '0;
        for (int r = 0; r < GRID_SIZE; r++) begin
            for (int c = 0; c < GRID_SIZE; c++) begin
                if (s[r*GRID_SIZE+c]) begin
                    if (r > 0) n[(r-1)*GRID_SIZE+c] = 1'b1;
                    if (r < GRID_SIZE-1) n[(r+1)*GRID_SIZE+c] = 1'b1;
                    if (c > 0) n[r*GRID_SIZE+c-1] = 1'b1;
                    if (c < GRID_SIZE-1) n[r*GRID_SIZE+c+1] = 1'b1;
`ifdef FLOOD_DIAG_EN
                    if (r > 0 && c > 0) n[(r-1)*GRID_SIZE+c-1] = 1'b1;
                    if (r > 0 && c < GRID_SIZE-1) n[(r-1)*GRID_SIZE+c+1] = 1'b1;
                    if (r < GRID_SIZE-1 && c > 0) n[(r+1)*GRID_SIZE+c-1] = 1'b1;
                    if (r < GRID_SIZE-1 && c < GRID_SIZE-1) n[(r+1)*GRID_SIZE+c+1] = 1'b1;
`endif
                end
            end
        end
        return n;
    endfunction

    // Next ring: neighbours of zero-count frontier tiles that are still eligible and not yet covered
    always_comb begin
        start_bit = TOTAL_TILES'(1) << start_index;
        accept    = start & ~mine_mask[start_index] & ~flagged[start_index] & ~revealed[start_index];
        grow_d    = nbr(frontier_q & zero_mask) & ~mine_mask & ~flagged & ~revealed & ~mask_q;
        done      = (grow_d == '0) || (iter_q == INDEX_BITS'(TOTAL_TILES - 1));
    end

    // Control FSM: accept an eligible start, expand one ring per clock, publish the result as a one-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            frontier_q <= '0;
            update_q   <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            apply_q    <= 1'b0;
        end else begin
            apply_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    mask_q     <= start_bit;
                    frontier_q <= start_bit;
                    iter_q     <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= EXPAND;
                end
            end else begin
                mask_q     <= mask_q | grow_d;
                frontier_q <= grow_d;
                iter_q     <= iter_q + 1'b1;
                if (done) begin
                    update_q <= mask_q | grow_d;
                    apply_q  <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            end
        end
    end

    assign busy         = busy_q;
    assign flood_update = update_q;
    assign flood_apply  = apply_q;
endmodule
